// File: rtl/bgpu_mem_pkg.sv
// Shared types for the block-memory AXI subordinate and the initiator-side adapter.
package bgpu_mem_pkg;

    localparam int unsigned IdWidth        = 4;
    localparam int unsigned AddrWidth      = 32;
    localparam int unsigned DataWidth      = 512;
    localparam int unsigned BlockAddrWidth = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int unsigned block_bytes(input int unsigned data_bits);
        return data_bits / 8;
    endfunction

    localparam int unsigned BlockBytes = block_bytes(DataWidth);

    typedef logic [IdWidth-1:0]        axi_id_t;
    typedef logic [BlockAddrWidth-1:0] block_addr_t;
    typedef logic [BlockBytes-1:0]     block_mask_t;
    typedef logic [DataWidth-1:0]      block_data_t;

    typedef struct packed {
        axi_id_t              id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [3:0]           cache;
        logic [2:0]           prot;
    } axi_ax_chan_t;

    typedef struct packed {
        block_data_t data;
        block_mask_t strb;
        logic        last;
    } axi_w_chan_t;

    typedef struct packed {
        axi_id_t     id;
        block_data_t data;
        logic [1:0]  resp;
        logic        last;
    } r_entry_t;

    typedef struct packed {
        axi_id_t    id;
        logic [1:0] resp;
    } b_entry_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_entry_t b;
        logic     r_valid;
        r_entry_t r;
    } axi_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ERR   = 2'd1,
        ST_WR_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/axi_to_block_mem_rsp_fifo.sv
// Small response FIFO with fill count; a pop frees space for a same-cycle push when full.
module axi_to_block_mem_rsp_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2,
    localparam int unsigned FillW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [FillW-1:0] o_fill
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    T                 r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [FillW-1:0] r_fill;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign o_full    = (r_fill == FillW'(Depth));
    assign o_empty   = (r_fill == '0);
    assign o_fill    = r_fill;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and fill bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_do_push) r_wptr <= ptr_inc(r_wptr);
            if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_do_push && !w_do_pop)      r_fill <= r_fill + FillW'(1);
            else if (w_do_pop && !w_do_push) r_fill <= r_fill - FillW'(1);
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/axi_to_block_mem.sv
// AXI subordinate terminating single-beat traffic onto a fixed-latency block SRAM port.
//
// state       | meaning
// ST_IDLE     | arbitrate legal reads/writes, accept error bursts
// ST_RD_ERR   | emit len+1 SLVERR R beats for a rejected burst read
// ST_WR_DRAIN | swallow W beats of a rejected burst write, then SLVERR B
module axi_to_block_mem
    import bgpu_mem_pkg::*;
#(
    parameter type         axi_req_t    = bgpu_mem_pkg::axi_req_t,
    parameter type         axi_rsp_t    = bgpu_mem_pkg::axi_rsp_t,
    parameter type         block_addr_t = bgpu_mem_pkg::block_addr_t,
    parameter type         block_mask_t = bgpu_mem_pkg::block_mask_t,
    parameter type         block_data_t = bgpu_mem_pkg::block_data_t,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned RspDepth     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  axi_req_t    axi_req_i,
    output axi_rsp_t    axi_rsp_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output block_addr_t mem_addr_o,
    output block_mask_t mem_be_o,
    output block_data_t mem_wdata_o,
    input  block_data_t mem_rdata_i
);

    localparam int unsigned AddrShift = $clog2(BlockBytes);
    localparam int unsigned FillW     = $clog2(RspDepth + 1);

    state_e                r_state;
    state_e                w_state_nxt;
    axi_id_t               r_err_id;
    logic [7:0]            r_err_len;
    logic [7:0]            r_beat;
    logic                  r_prio_wr;
    logic [MemLatency-1:0] r_pipe_vld;
    axi_id_t               r_pipe_id [MemLatency];

    int unsigned      w_inflight;
    logic             w_live;
    logic             w_rd_credit;
    logic             w_rd_cand, w_wr_cand;
    logic             w_gnt_rd, w_gnt_wr;
    logic             w_rd_issue, w_wr_issue;
    logic             w_aw_ready, w_w_ready;
    logic             w_beat_inc;
    logic             w_r_push, w_b_push;
    r_entry_t         w_r_push_data, w_r_head;
    b_entry_t         w_b_push_data, w_b_head;
    logic             w_r_full, w_r_empty, w_b_full, w_b_empty;
    logic [FillW-1:0] w_r_fill, w_b_fill;
    logic             w_unused;

    assign w_live      = !rst_i;
    assign w_rd_credit = (32'(w_r_fill) + w_inflight) < RspDepth;

    // Reads currently travelling through the memory latency pipeline.
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < MemLatency; i++) begin
            if (r_pipe_vld[i]) w_inflight++;
        end
    end

    // Next state, arbitration, handshakes and FIFO pushes.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cand     = 1'b0;
        w_wr_cand     = 1'b0;
        w_gnt_rd      = 1'b0;
        w_gnt_wr      = 1'b0;
        w_rd_issue    = 1'b0;
        w_wr_issue    = 1'b0;
        w_aw_ready    = 1'b0;
        w_w_ready     = 1'b0;
        w_beat_inc    = 1'b0;
        w_r_push      = 1'b0;
        w_r_push_data = '0;
        w_b_push      = 1'b0;
        w_b_push_data = '0;
        unique case (r_state)
            ST_IDLE: begin
                w_rd_cand = axi_req_i.ar_valid && ((axi_req_i.ar.len != 8'd0) || w_rd_credit);
                w_wr_cand = axi_req_i.aw_valid &&
                            ((axi_req_i.aw.len != 8'd0) || (axi_req_i.w_valid && !w_b_full));
                if (w_rd_cand && w_wr_cand) begin
                    w_gnt_wr = r_prio_wr;
                    w_gnt_rd = !r_prio_wr;
                end else begin
                    w_gnt_wr = w_wr_cand;
                    w_gnt_rd = w_rd_cand;
                end
                if (w_gnt_rd) begin
                    if (axi_req_i.ar.len == 8'd0) w_rd_issue  = 1'b1;
                    else                          w_state_nxt = ST_RD_ERR;
                end
                if (w_gnt_wr) begin
                    w_aw_ready = 1'b1;
                    if (axi_req_i.aw.len == 8'd0) begin
                        w_w_ready          = 1'b1;
                        w_wr_issue         = 1'b1;
                        w_b_push           = 1'b1;
                        w_b_push_data.id   = axi_req_i.aw.id;
                        w_b_push_data.resp = RESP_OKAY;
                    end else begin
                        w_state_nxt = ST_WR_DRAIN;
                    end
                end
            end
            ST_RD_ERR: begin
                // Waiting for in-flight reads to land keeps R beats in issue order.
                if (!w_r_full && (w_inflight == 0)) begin
                    w_r_push           = 1'b1;
                    w_r_push_data.id   = r_err_id;
                    w_r_push_data.resp = RESP_SLVERR;
                    w_r_push_data.last = (r_beat == r_err_len);
                    if (r_beat == r_err_len) w_state_nxt = ST_IDLE;
                    else                     w_beat_inc  = 1'b1;
                end
            end
            ST_WR_DRAIN: begin
                w_w_ready = !axi_req_i.w.last || !w_b_full;
                if (axi_req_i.w_valid && w_w_ready && axi_req_i.w.last) begin
                    w_b_push           = 1'b1;
                    w_b_push_data.id   = r_err_id;
                    w_b_push_data.resp = RESP_SLVERR;
                    w_state_nxt        = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_pipe_vld[MemLatency-1]) begin
            w_r_push           = 1'b1;
            w_r_push_data.id   = r_pipe_id[MemLatency-1];
            w_r_push_data.data = mem_rdata_i;
            w_r_push_data.resp = RESP_OKAY;
            w_r_push_data.last = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Round-robin pointer and error-burst context; write wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio_wr <= 1'b1;
            r_err_id  <= '0;
            r_err_len <= '0;
            r_beat    <= '0;
        end else begin
            if (w_gnt_rd || w_gnt_wr) r_prio_wr <= w_gnt_rd;
            if (w_gnt_rd && (axi_req_i.ar.len != 8'd0)) begin
                r_err_id  <= axi_req_i.ar.id;
                r_err_len <= axi_req_i.ar.len;
                r_beat    <= '0;
            end else if (w_gnt_wr && (axi_req_i.aw.len != 8'd0)) begin
                r_err_id <= axi_req_i.aw.id;
            end else if (w_beat_inc) begin
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // Read-data pipeline: tracks {valid, id} alongside the memory latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_issue;
            for (int i = 1; i < MemLatency; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
        end
    end

    // Pipeline ids need no reset; they are qualified by r_pipe_vld.
    always_ff @(posedge clk_i) begin
        r_pipe_id[0] <= axi_req_i.ar.id;
        for (int i = 1; i < MemLatency; i++) r_pipe_id[i] <= r_pipe_id[i-1];
    end

    axi_to_block_mem_rsp_fifo #(.T(r_entry_t), .Depth(RspDepth)) u_r_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_r_push),
        .i_data  (w_r_push_data),
        .i_pop   (axi_rsp_o.r_valid && axi_req_i.r_ready),
        .o_data  (w_r_head),
        .o_full  (w_r_full),
        .o_empty (w_r_empty),
        .o_fill  (w_r_fill)
    );

    axi_to_block_mem_rsp_fifo #(.T(b_entry_t), .Depth(RspDepth)) u_b_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_b_push),
        .i_data  (w_b_push_data),
        .i_pop   (axi_rsp_o.b_valid && axi_req_i.b_ready),
        .o_data  (w_b_head),
        .o_full  (w_b_full),
        .o_empty (w_b_empty),
        .o_fill  (w_b_fill)
    );

    // AXI response outputs, held quiet while reset is asserted.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.ar_ready = w_live && w_gnt_rd;
        axi_rsp_o.aw_ready = w_live && w_aw_ready;
        axi_rsp_o.w_ready  = w_live && w_w_ready;
        axi_rsp_o.r_valid  = w_live && !w_r_empty;
        axi_rsp_o.r        = w_r_head;
        axi_rsp_o.b_valid  = w_live && !w_b_empty;
        axi_rsp_o.b        = w_b_head;
    end

    assign mem_req_o   = w_live && (w_rd_issue || w_wr_issue);
    assign mem_we_o    = w_wr_issue;
    assign mem_addr_o  = w_wr_issue ? block_addr_t'(axi_req_i.aw.addr >> AddrShift)
                                    : block_addr_t'(axi_req_i.ar.addr >> AddrShift);
    assign mem_be_o    = axi_req_i.w.strb;
    assign mem_wdata_o = axi_req_i.w.data;

    assign w_unused = ^{axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.ar.cache, axi_req_i.ar.prot,
                        axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.cache, axi_req_i.aw.prot,
                        axi_req_i.ar.addr, axi_req_i.aw.addr, w_b_fill};

endmodule

// File: tb/tb_axi_to_block_mem.sv
// Directed bench for axi_to_block_mem with a behavioural 1-cycle block SRAM.
module tb_axi_to_block_mem;
    import bgpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    axi_req_t    req;
    axi_rsp_t    rsp;
    logic        mem_req, mem_we;
    block_addr_t mem_addr;
    block_mask_t mem_be;
    block_data_t mem_wdata, mem_rdata;

    block_data_t tb_mem [16];
    bit          mem_inited;
    int          n_req, n_rd;
    int          n_err, n_chk;
    int          base_req, base_rd, cnt;
    bit          ok;

    always #5 clk = ~clk;

    axi_to_block_mem dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .axi_req_i  (req),
        .axi_rsp_o  (rsp),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_be_o   (mem_be),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic block_data_t blk_val(input int i);
        logic [31:0] w;
        if (i == 1) return {64{8'hA5}};
        w = 32'h1000_0000 + 32'(i);
        return {16{w}};
    endfunction

    // Memory model: read data registered one cycle after the request.
    always @(posedge clk) begin
        if (rst && !mem_inited) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= blk_val(i);
            mem_inited <= 1'b1;
        end
        if (mem_req) begin
            n_req <= n_req + 1;
            if (mem_we) begin
                for (int b = 0; b < 64; b++)
                    if (mem_be[b]) tb_mem[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                n_rd      <= n_rd + 1;
                mem_rdata <= tb_mem[mem_addr[3:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ar(input int id, input logic [31:0] addr, input logic [7:0] len);
        req.ar_valid = 1'b1;
        req.ar.id    = 4'(id);
        req.ar.addr  = addr;
        req.ar.len   = len;
    endtask

    task automatic set_aw(input int id, input logic [31:0] addr, input logic [7:0] len);
        req.aw_valid = 1'b1;
        req.aw.id    = 4'(id);
        req.aw.addr  = addr;
        req.aw.len   = len;
    endtask

    task automatic set_w(input logic [31:0] data, input logic [63:0] strb, input logic last);
        req.w_valid = 1'b1;
        req.w.data  = 512'(data);
        req.w.strb  = strb;
        req.w.last  = last;
    endtask

    // Called right after a negedge+1 sample point; advances until r_valid or budget expires.
    task automatic wait_rvalid(output bit found);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp.r_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_err = 0; n_chk = 0;
        req   = '0;
        rst   = 1'b1;
        @(negedge clk); @(negedge clk);
        set_ar(1, 32'h0, 8'd0); set_aw(2, 32'h0, 8'd0); set_w(32'h0, 64'h0, 1'b1);
        #1;
        check("rst_ar_ready", rsp.ar_ready, 1'b0);
        check("rst_aw_ready", rsp.aw_ready, 1'b0);
        check("rst_w_ready",  rsp.w_ready,  1'b0);
        check("rst_mem_req",  mem_req,      1'b0);
        @(negedge clk);
        req = '0; rst = 1'b0;
        #1;
        check("rst_r_valid", rsp.r_valid, 1'b0);
        check("rst_b_valid", rsp.b_valid, 1'b0);

        // Arbitration: write first, then alternate.
        @(negedge clk);
        req.r_ready = 1'b1; req.b_ready = 1'b1;
        set_ar(1, 32'h0, 8'd0); set_aw(2, 32'h3C0, 8'd0); set_w(32'h0, 64'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("arb_req", mem_req, 1'b1);
            check("arb_we",  mem_we,  (i % 2 == 0) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Single read.
        set_ar(3, 32'h40, 8'd0);
        #1;
        check("rd_ar_ready", rsp.ar_ready, 1'b1);
        check("rd_mem_we",   mem_we,       1'b0);
        check("rd_mem_addr", mem_addr,     16'd1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        #1;
        check("rd_r_valid_early", rsp.r_valid, 1'b0);
        @(negedge clk); #1;
        check("rd_r_valid", rsp.r_valid, 1'b1);
        check("rd_r_id",    rsp.r.id,    4'd3);
        check("rd_r_data",  rsp.r.data,  {64{8'hA5}});
        check("rd_r_resp",  rsp.r.resp,  RESP_OKAY);
        check("rd_r_last",  rsp.r.last,  1'b1);
        @(negedge clk); #1;
        check("rd_r_drained", rsp.r_valid, 1'b0);

        // Single write.
        @(negedge clk);
        set_aw(5, 32'h80, 8'd0); set_w(32'h11223344, 64'h000F, 1'b1);
        #1;
        check("wr_aw_ready", rsp.aw_ready, 1'b1);
        check("wr_w_ready",  rsp.w_ready,  1'b1);
        check("wr_mem_we",   mem_we,       1'b1);
        check("wr_mem_addr", mem_addr,     16'd2);
        check("wr_mem_be",   mem_be,       64'h000F);
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        #1;
        check("wr_b_valid", rsp.b_valid, 1'b1);
        check("wr_b_id",    rsp.b.id,    4'd5);
        check("wr_b_resp",  rsp.b.resp,  RESP_OKAY);
        check("wr_mem_content", tb_mem[2][63:0], 64'h1000_0002_1122_3344);

        // W ahead of AW is held off.
        @(negedge clk);
        set_w(32'hCAFE0000, 64'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("w_early_ready", rsp.w_ready, 1'b0);
            @(negedge clk);
        end
        set_aw(6, 32'hC0, 8'd0);
        #1;
        check("w_late_aw_ready", rsp.aw_ready, 1'b1);
        check("w_late_w_ready",  rsp.w_ready,  1'b1);
        @(negedge clk);
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Back-pressure with RspDepth=2.
        req.r_ready = 1'b0;
        base_rd = n_rd;
        set_ar(8, 32'h100, 8'd0); #1;
        check("bp_ar0", rsp.ar_ready, 1'b1);
        @(negedge clk); set_ar(9, 32'h140, 8'd0); #1;
        check("bp_ar1", rsp.ar_ready, 1'b1);
        @(negedge clk); set_ar(10, 32'h180, 8'd0); #1;
        check("bp_stall0", rsp.ar_ready, 1'b0);
        @(negedge clk); #1;
        check("bp_stall1", rsp.ar_ready, 1'b0);
        @(negedge clk); #1;
        check("bp_stall2", rsp.ar_ready, 1'b0);
        check("bp_rd_count", n_rd - base_rd, 2);
        @(negedge clk); req.r_ready = 1'b1; #1;
        check("bp_r0_id",   rsp.r.id,   4'd8);
        check("bp_r0_data", rsp.r.data, blk_val(4));
        check("bp_still_stalled", rsp.ar_ready, 1'b0);
        @(negedge clk); #1;
        check("bp_r1_id", rsp.r.id, 4'd9);
        check("bp_ar2",   rsp.ar_ready, 1'b1);
        @(negedge clk); set_ar(11, 32'h1C0, 8'd0); #1;
        check("bp_ar3", rsp.ar_ready, 1'b1);
        @(negedge clk); req.ar_valid = 1'b0; #1;
        check("bp_r2_id",   rsp.r.id,   4'd10);
        check("bp_r2_data", rsp.r.data, blk_val(6));
        @(negedge clk); #1;
        check("bp_r3_id",   rsp.r.id,   4'd11);
        check("bp_r3_data", rsp.r.data, blk_val(7));
        repeat (2) @(negedge clk);

        // Error read burst.
        base_req = n_req;
        set_ar(7, 32'h0, 8'd3); #1;
        check("erd_ar_ready", rsp.ar_ready, 1'b1);
        check("erd_no_mem",   mem_req,      1'b0);
        @(negedge clk); req.ar_valid = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            wait_rvalid(ok);
            check("erd_beat_seen", ok,         1'b1);
            check("erd_id",        rsp.r.id,   4'd7);
            check("erd_resp",      rsp.r.resp, RESP_SLVERR);
            check("erd_data",      rsp.r.data, 512'd0);
            check("erd_last",      rsp.r.last, (k == 3) ? 1'b1 : 1'b0);
            @(negedge clk); #1;
        end
        check("erd_done", rsp.r_valid, 1'b0);

        // Error write burst.
        @(negedge clk);
        set_aw(4, 32'h0, 8'd2); #1;
        check("ewr_aw_ready", rsp.aw_ready, 1'b1);
        check("ewr_w_ready0", rsp.w_ready,  1'b0);
        @(negedge clk); req.aw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_w(32'(k), 64'hFFFF, (k == 2) ? 1'b1 : 1'b0); #1;
            check("ewr_w_ready", rsp.w_ready, 1'b1);
            check("ewr_b_early", rsp.b_valid, 1'b0);
            @(negedge clk);
        end
        req.w_valid = 1'b0; #1;
        check("ewr_b_valid", rsp.b_valid, 1'b1);
        check("ewr_b_id",    rsp.b.id,    4'd4);
        check("ewr_b_resp",  rsp.b.resp,  RESP_SLVERR);
        check("err_no_mem",  n_req - base_req, 0);
        @(negedge clk); #1;
        check("ewr_b_drained", rsp.b_valid, 1'b0);

        // Reset one cycle after an AR handshake.
        @(negedge clk);
        set_ar(12, 32'h40, 8'd0); #1;
        check("rrst_ar_ready", rsp.ar_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        set_ar(13, 32'h40, 8'd0); set_aw(13, 32'h0, 8'd0); set_w(32'h0, 64'h0, 1'b1);
        #1;
        check("rrst_ar_ready0", rsp.ar_ready, 1'b0);
        check("rrst_aw_ready0", rsp.aw_ready, 1'b0);
        check("rrst_w_ready0",  rsp.w_ready,  1'b0);
        check("rrst_mem_req0",  mem_req,      1'b0);
        @(negedge clk);
        req = '0; req.r_ready = 1'b1; req.b_ready = 1'b1; rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp.r_valid !== 1'b0) cnt++;
            @(negedge clk);
        end
        check("rrst_no_r_valid", cnt, 0);
        set_ar(14, 32'h40, 8'd0); #1;
        check("rrst_new_ar_ready", rsp.ar_ready, 1'b1);
        @(negedge clk); req.ar_valid = 1'b0; #1;
        wait_rvalid(ok);
        check("rrst_new_seen", ok,         1'b1);
        check("rrst_new_id",   rsp.r.id,   4'd14);
        check("rrst_new_data", rsp.r.data, {64{8'hA5}});
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
